heap_array_allocator: RTL and testbench

Shared allocator for the heap array pool: serialises alloc/free requests from up to NRequesters program engines through one round-robin arbiter. Alloc reuses the freed-array stack first, otherwise bumps the high-water counter. Sits beside heapMem/arraySizes; clears the new array's size entry and, optionally, its heap area.

---
 rtl/heap_alloc_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/heap_array_allocator.sv | 233 +++++++++++++++++++++++
 tb/tb_heap_array_allocator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_alloc_pkg.sv
// heap_alloc_pkg: shared constants for the heap array allocator.
//   - error codes returned with each grant
//   - FSM state encoding (plain localparams for legacy tool compatibility)
//   - request op codes
//   - idx_width(): index width helper that never returns 0
package heap_alloc_pkg;

   typedef logic [1:0] err_t;
   localparam err_t ERR_NONE        = 2'd0;
   localparam err_t ERR_EXHAUSTED   = 2'd1;
   localparam err_t ERR_DOUBLE_FREE = 2'd2;
   localparam err_t ERR_RANGE       = 2'd3;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_EXEC  = 2'd1;
   localparam state_t ST_CLEAR = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_FREE  = 1'b1;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot picker.
// Ports:
//   req      - request vector
//   mask     - 1 excludes that requester from this pick
//   ptr      - index where the search starts (highest priority)
//   gnt      - one-hot winner (all zero when nothing eligible)
//   gnt_idx  - binary index of the winner
//   any      - a winner exists
module rr_arbiter
   import heap_alloc_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned PtrW = idx_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    mask,
   input  logic [PtrW-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [PtrW-1:0] gnt_idx,
   output logic            any
);

   logic [PtrW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int i = 0; i < int'(N); i++) begin
         cand = PtrW'((int'(ptr) + i) % int'(N));
         if (!any && req[cand] && !mask[cand]) begin
            any       = 1'b1;
            gnt_idx   = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/heap_array_allocator.sv
// heap_array_allocator: shared alloc/free engine for the heap array pool.
// Requests from NRequesters engines are serialised by a round-robin arbiter.
// Alloc reuses the freed-array stack first, else bumps the high-water count.
// Optional macro HEAP_ALLOC_CLEAR_EN: zero the new array's NArea heap words
// before granting; when undefined the heap write port is tied off.
// Ports:
//   clock, reset                 - clock, async active-high reset
//   req_valid/req_free/req_array - per-requester request, op, array to free
//   grant, rsp_array, rsp_error  - one-cycle completion pulse and result
//   size_clr_valid/_array        - pulse to zero arraySizes[] of a new array
//   heap_wr_valid/_addr          - heap zero-write strobe and word address
//   allocs, in_use               - high-water count, live array count
module heap_array_allocator
   import heap_alloc_pkg::*;
#(
   parameter int unsigned MemoryElementWidth = 12,
   parameter int unsigned NArrays            = 8,
   parameter int unsigned NArea              = 4,
   parameter int unsigned NRequesters        = 4
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [NRequesters-1:0]                    req_valid,
   input  logic [NRequesters-1:0]                    req_free,
   input  logic [NRequesters*MemoryElementWidth-1:0] req_array,
   output logic [NRequesters-1:0]                    grant,
   output logic [MemoryElementWidth-1:0]             rsp_array,
   output logic [1:0]                                rsp_error,
   output logic                                      size_clr_valid,
   output logic [MemoryElementWidth-1:0]             size_clr_array,
   output logic                                      heap_wr_valid,
   output logic [MemoryElementWidth-1:0]             heap_wr_addr,
   output logic [MemoryElementWidth-1:0]             allocs,
   output logic [MemoryElementWidth-1:0]             in_use
);

   localparam int unsigned MEW  = MemoryElementWidth;
   localparam int unsigned PtrW = idx_width(NRequesters);
   localparam int unsigned StkW = idx_width(NArrays);
   localparam logic [MEW-1:0] NArraysW = MEW'(NArrays);

   state_t                 state_q;
   logic [PtrW-1:0]        ptr_q;
   logic [NRequesters-1:0] win_oh_q;
   logic                   op_q;
   logic [MEW-1:0]         arr_q;
   logic [MEW-1:0]         res_arr_q;
   err_t                   res_err_q;
   logic [MEW-1:0]         freed_top_q;
   logic [MEW-1:0]         freed_q [NArrays];
   logic [NArrays-1:0]     used_q;
   logic [MEW-1:0]         allocs_q;
   logic [MEW-1:0]         in_use_q;
   logic [NRequesters-1:0] grant_q;
   logic [MEW-1:0]         rsp_array_q;
   err_t                   rsp_error_q;
   logic                   size_clr_valid_q;
   logic [MEW-1:0]         size_clr_array_q;

   logic [NRequesters-1:0] arb_gnt;
   logic [PtrW-1:0]        arb_idx;
   logic                   arb_any;
   logic [PtrW-1:0]        next_ptr;
   logic [MEW-1:0]         sel_array;

   logic                   ex_ok;
   logic                   ex_pop;
   logic                   ex_bump;
   logic [MEW-1:0]         ex_arr;
   err_t                   ex_err;

   // The requester whose grant pulse is showing still holds req_valid this
   // cycle; masking it stops a completed request from being served twice.
   rr_arbiter #(
      .N    (NRequesters),
      .PtrW (PtrW)
   ) u_arb (
      .req     (req_valid),
      .mask    (grant_q),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   assign next_ptr = PtrW'((int'(arb_idx) + 1) % int'(NRequesters));

   always_comb begin
      sel_array = '0;
      for (int i = 0; i < int'(NRequesters); i++) begin
         if (arb_idx == PtrW'(i)) sel_array = req_array[i*MEW +: MEW];
      end
   end

   // Outcome of the latched request, consumed in EXEC.
   always_comb begin
      ex_ok   = 1'b0;
      ex_pop  = 1'b0;
      ex_bump = 1'b0;
      ex_arr  = '0;
      ex_err  = ERR_NONE;
      if (op_q == OP_ALLOC) begin
         if (freed_top_q != '0) begin
            ex_ok  = 1'b1;
            ex_pop = 1'b1;
            ex_arr = freed_q[StkW'(freed_top_q - 1'b1)];
         end else if (allocs_q < NArraysW) begin
            ex_ok   = 1'b1;
            ex_bump = 1'b1;
            ex_arr  = allocs_q;
         end else begin
            ex_err = ERR_EXHAUSTED;
         end
      end else begin
         ex_arr = arr_q;
         if (arr_q >= NArraysW) begin
            ex_err = ERR_RANGE;
         end else if (!used_q[StkW'(arr_q)]) begin
            ex_err = ERR_DOUBLE_FREE;
         end else begin
            ex_ok = 1'b1;
         end
      end
   end

`ifdef HEAP_ALLOC_CLEAR_EN
   localparam int unsigned KW = idx_width(NArea);
   localparam logic [MEW-1:0] NAreaW = MEW'(NArea);
   logic [KW-1:0]  clr_k_q;
   logic           heap_wr_valid_q;
   logic [MEW-1:0] heap_wr_addr_q;
   assign heap_wr_valid = heap_wr_valid_q;
   assign heap_wr_addr  = heap_wr_addr_q;
`else
   logic [MEW-1:0] unused_narea;
   assign unused_narea  = MEW'(NArea);
   assign heap_wr_valid = 1'b0;
   assign heap_wr_addr  = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         ptr_q            <= '0;
         win_oh_q         <= '0;
         op_q             <= OP_ALLOC;
         arr_q            <= '0;
         res_arr_q        <= '0;
         res_err_q        <= ERR_NONE;
         freed_top_q      <= '0;
         used_q           <= '0;
         allocs_q         <= '0;
         in_use_q         <= '0;
         grant_q          <= '0;
         rsp_array_q      <= '0;
         rsp_error_q      <= ERR_NONE;
         size_clr_valid_q <= 1'b0;
         size_clr_array_q <= '0;
         for (int i = 0; i < int'(NArrays); i++) freed_q[i] <= '0;
`ifdef HEAP_ALLOC_CLEAR_EN
         clr_k_q          <= '0;
         heap_wr_valid_q  <= 1'b0;
         heap_wr_addr_q   <= '0;
`endif
      end else begin
         grant_q          <= '0;
         size_clr_valid_q <= 1'b0;
`ifdef HEAP_ALLOC_CLEAR_EN
         heap_wr_valid_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  win_oh_q <= arb_gnt;
                  op_q     <= req_free[arb_idx];
                  arr_q    <= sel_array;
                  ptr_q    <= next_ptr;
                  state_q  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_arr_q <= ex_arr;
               res_err_q <= ex_err;
               state_q   <= ST_RESP;
               if (ex_ok && op_q == OP_ALLOC) begin
                  used_q[StkW'(ex_arr)] <= 1'b1;
                  in_use_q              <= in_use_q + 1'b1;
                  size_clr_valid_q      <= 1'b1;
                  size_clr_array_q      <= ex_arr;
                  arr_q                 <= ex_arr;
                  if (ex_pop)  freed_top_q <= freed_top_q - 1'b1;
                  if (ex_bump) allocs_q    <= allocs_q + 1'b1;
`ifdef HEAP_ALLOC_CLEAR_EN
                  clr_k_q <= '0;
                  state_q <= ST_CLEAR;
`endif
               end else if (ex_ok) begin
                  // Bitmap check guarantees depth <= NArrays, no overflow.
                  freed_q[StkW'(freed_top_q)] <= arr_q;
                  freed_top_q                 <= freed_top_q + 1'b1;
                  used_q[StkW'(arr_q)]        <= 1'b0;
                  in_use_q                    <= in_use_q - 1'b1;
               end
            end
            ST_CLEAR: begin
`ifdef HEAP_ALLOC_CLEAR_EN
               heap_wr_valid_q <= 1'b1;
               heap_wr_addr_q  <= arr_q * NAreaW + MEW'(clr_k_q);
               clr_k_q         <= clr_k_q + 1'b1;
               if (clr_k_q == KW'(NArea - 1)) state_q <= ST_RESP;
`else
               state_q <= ST_IDLE;
`endif
            end
            ST_RESP: begin
               grant_q     <= win_oh_q;
               rsp_array_q <= res_arr_q;
               rsp_error_q <= res_err_q;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant          = grant_q;
   assign rsp_array      = rsp_array_q;
   assign rsp_error      = rsp_error_q;
   assign size_clr_valid = size_clr_valid_q;
   assign size_clr_array = size_clr_array_q;
   assign allocs         = allocs_q;
   assign in_use         = in_use_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
// Bench for heap_array_allocator: directed plan plus randomized ops checked
// against a queue-based pool model. Covers the clear feature when
// HEAP_ALLOC_CLEAR_EN is defined.
module tb_heap_array_allocator;
   import heap_alloc_pkg::*;

   localparam int MEW   = 12;
   localparam int NARR  = 8;
   localparam int NAREA = 4;
   localparam int NREQ  = 4;
`ifdef HEAP_ALLOC_CLEAR_EN
   localparam int ExtraLat = NAREA;
`else
   localparam int ExtraLat = 0;
`endif

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_free = '0;
   logic [NREQ*MEW-1:0]   req_array = '0;
   logic [NREQ-1:0]       grant;
   logic [MEW-1:0]        rsp_array;
   logic [1:0]            rsp_error;
   logic                  size_clr_valid;
   logic [MEW-1:0]        size_clr_array;
   logic                  heap_wr_valid;
   logic [MEW-1:0]        heap_wr_addr;
   logic [MEW-1:0]        allocs;
   logic [MEW-1:0]        in_use;

   always #5 clock = ~clock;

   heap_array_allocator #(
      .MemoryElementWidth (MEW),
      .NArrays            (NARR),
      .NArea              (NAREA),
      .NRequesters        (NREQ)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_free       (req_free),
      .req_array      (req_array),
      .grant          (grant),
      .rsp_array      (rsp_array),
      .rsp_error      (rsp_error),
      .size_clr_valid (size_clr_valid),
      .size_clr_array (size_clr_array),
      .heap_wr_valid  (heap_wr_valid),
      .heap_wr_addr   (heap_wr_addr),
      .allocs         (allocs),
      .in_use         (in_use)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pool model: stack of freed arrays, high-water count, in-use set.
   int m_stack[$];
   int m_allocs;
   int m_inuse;
   bit m_used[NARR];

   task automatic m_reset();
      m_stack.delete();
      m_allocs = 0;
      m_inuse  = 0;
      for (int i = 0; i < NARR; i++) m_used[i] = 1'b0;
   endtask

   task automatic m_apply(input bit free, input int arr, output int e_arr, output int e_err);
      e_arr = 0;
      e_err = 0;
      if (!free) begin
         if (m_stack.size() > 0) e_arr = m_stack.pop_back();
         else if (m_allocs < NARR) begin
            e_arr = m_allocs;
            m_allocs++;
         end else e_err = 1;
         if (e_err == 0) begin
            m_used[e_arr] = 1'b1;
            m_inuse++;
         end
      end else begin
         e_arr = arr;
         if (arr >= NARR) e_err = 3;
         else if (!m_used[arr]) e_err = 2;
         else begin
            m_stack.push_back(arr);
            m_used[arr] = 1'b0;
            m_inuse--;
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " grant"}, 32'(grant), 0);
      check({tag, " rsp"}, {18'd0, rsp_error, rsp_array}, 0);
      check({tag, " sizeclr"}, {19'd0, size_clr_valid, size_clr_array}, 0);
      check({tag, " heapwr"}, {19'd0, heap_wr_valid, heap_wr_addr}, 0);
      check({tag, " allocs"}, 32'(allocs), 0);
      check({tag, " in_use"}, 32'(in_use), 0);
   endtask

   // Called at a negedge; asynchronous reset must clear outputs at once.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      req_valid = '0;
      #1;
      check_idle_outputs(tag);
      @(negedge clock);
      reset = 1'b0;
      m_reset();
   endtask

   // One request from requester r, run to its grant and fully checked.
   task automatic do_op(input int r, input bit free, input int arr, input string tag);
      int e_arr, e_err, cyc, n_sc, sc_arr, exp_hw;
      int hw[$];
      int hw_cyc[$];
      bit got, ok_alloc;
      logic [NREQ-1:0] exp_g;
      m_apply(free, arr, e_arr, e_err);
      ok_alloc = !free && (e_err == 0);
      req_valid[r] = 1'b1;
      req_free[r]  = free;
      req_array[r*MEW +: MEW] = arr[MEW-1:0];
      cyc = 0; got = 0; n_sc = 0; sc_arr = -1;
      while (!got && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (size_clr_valid) begin
            n_sc++;
            sc_arr = int'(size_clr_array);
         end
         if (heap_wr_valid) begin
            hw.push_back(int'(heap_wr_addr));
            hw_cyc.push_back(cyc);
         end
         if (grant != '0) got = 1'b1;
      end
      check({tag, " grant_seen"}, 32'(got), 1);
      if (got) begin
         exp_g = '0;
         exp_g[r] = 1'b1;
         check({tag, " grant_onehot"}, 32'(grant), 32'(exp_g));
         check({tag, " rsp_error"}, 32'(rsp_error), e_err);
         check({tag, " rsp_array"}, 32'(rsp_array), e_arr);
         check({tag, " latency"}, cyc, 3 + (ok_alloc ? ExtraLat : 0));
      end
      check({tag, " size_clr_count"}, n_sc, ok_alloc ? 1 : 0);
      if (ok_alloc) check({tag, " size_clr_array"}, sc_arr, e_arr);
      exp_hw = ok_alloc ? ExtraLat : 0;
      check({tag, " heap_wr_count"}, hw.size(), exp_hw);
      for (int k = 0; k < hw.size() && k < exp_hw; k++) begin
         check({tag, " heap_wr_addr"}, hw[k], e_arr * NAREA + k);
         check({tag, " heap_wr_cycle"}, hw_cyc[k], hw_cyc[0] + k);
      end
      check({tag, " allocs"}, 32'(allocs), m_allocs);
      check({tag, " in_use"}, 32'(in_use), m_inuse);
      req_valid[r] = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int order[$];
      int gcyc[$];
      int garr[$];
      int cyc, e_arr, e_err, r, a;
      bit fr, seen;

      // Reset state
      #3;
      check_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b0;
      m_reset();

      // Three allocs, then free/realloc from the stack
      for (int i = 0; i < 3; i++) do_op(0, 1'b0, 0, "alloc_seq");
      check("alloc_seq allocs_is_3", 32'(allocs), 3);
      do_op(0, 1'b1, 1, "free1");
      do_op(0, 1'b0, 0, "realloc");
      check("realloc got_1", 32'(rsp_array), 1);
      check("realloc allocs_is_3", 32'(allocs), 3);

      // Double free and out-of-range free
      do_op(1, 1'b1, 1, "free1b");
      do_op(2, 1'b1, 1, "double_free");
      do_op(3, 1'b1, 9, "range");

      // Exhaustion
      do_reset("reset2");
      for (int i = 0; i < 9; i++) do_op(i % NREQ, 1'b0, 0, "exhaust");
      check("exhaust ninth_err", 32'(rsp_error), 32'(ERR_EXHAUSTED));
      check("exhaust in_use_8", 32'(in_use), 8);

      // All requesters at once: round-robin order, back-to-back spacing
      do_reset("reset3");
      req_free = '0;
      req_valid = '1;
      cyc = 0;
      while (order.size() < NREQ && cyc < 100) begin
         @(negedge clock);
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
               order.push_back(i);
               gcyc.push_back(cyc);
               garr.push_back(int'(rsp_array));
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      check("concurrent grants", order.size(), NREQ);
      for (int k = 0; k < order.size(); k++) begin
         m_apply(1'b0, 0, e_arr, e_err);
         check("concurrent order", order[k], k);
         check("concurrent array", garr[k], e_arr);
         check("concurrent cycle", gcyc[k], (k + 1) * (3 + ExtraLat));
      end
      @(negedge clock);
      check("concurrent in_use", 32'(in_use), m_inuse);

      // Randomized ops against the model
      do_reset("reset4");
      repeat (60) begin
         r  = $urandom_range(0, NREQ - 1);
         fr = ($urandom_range(0, 9) < 4);
         a  = fr ? $urandom_range(0, 9) : $urandom_range(0, 4095);
         do_op(r, fr, a, "random");
      end

`ifdef HEAP_ALLOC_CLEAR_EN
      // Reset in the middle of CLEAR: outputs drop at once, no grant follows
      do_reset("reset5");
      do_op(0, 1'b0, 0, "clr_a0");
      do_op(0, 1'b0, 0, "clr_a1");
      req_valid[1] = 1'b1;
      req_free[1]  = 1'b0;
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 20) begin
         @(negedge clock);
         cyc++;
         seen = heap_wr_valid;
      end
      check("midclear wr_seen", 32'(seen), 1);
      check("midclear wr_addr", 32'(heap_wr_addr), 8);
      do_reset("midclear");
      seen = 1'b0;
      repeat (12) begin
         @(negedge clock);
         if (grant != '0) seen = 1'b1;
      end
      check("midclear no_grant", 32'(seen), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
